mips_cpu_muldiv: RTL and testbench
==================================

Name: mips_cpu_muldiv

Overview:
Iterative, parameterised multiply/divide unit that owns the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the combinational ALU in the execute stage.
- Multiply/divide take multiple cycles; the controller uses busy to stall MFHI/MFLO and any new mul/div.
- Radix-2: one partial product or one restoring-division step per cycle, on a shared datapath.

Parameters:
WIDTH, 32, operand width and HI/LO width. Must be even and >= 4.
CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled on clk rising edge
funct  input  6  0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
rs_content  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
rt_content  input  WIDTH  multiplier / divisor
busy  output  1  mul/div in progress; new requests are ignored while high
done  output  1  one-cycle pulse when HI/LO have been updated by a mul/div
div_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with rt_content==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; hi=lo=0; busy=done=div_zero=0; counter=0.
  - Reset asserted mid-operation aborts it; no done pulse follows.
- States: IDLE, MUL, DIV, FIX.
- Acceptance: start=1 in IDLE on edge E0. Any other funct is ignored; state stays IDLE.
- MTHI/MTLO:
  - hi (or lo) <= rs_content at E0.
  - No busy, no done.
  - Accepted only in IDLE.
- MULT/MULTU:
  - At E0: latch |operands| (signed) or raw operands (unsigned); record result sign = rs[W-1]^rt[W-1] (signed only); state=MUL; counter=WIDTH.
  - Each MUL cycle: add-shift one multiplier bit into a 2*WIDTH accumulator; counter decrements.
  - When counter reaches 0, go to FIX.
  - FIX: two's-complement negate the 2*WIDTH product if sign is set, then {hi,lo} <= product.
  - done pulses during the cycle after the FIX edge; state returns to IDLE.
- DIV/DIVU:
  - At E0, if rt_content==0: state=FIX directly. hi/lo are unchanged; done and div_zero pulse after that edge.
  - Otherwise: restoring division on magnitudes, WIDTH iterations, then FIX.
  - lo = quotient, truncated toward zero. hi = remainder, with the sign of the dividend.
  - Signed overflow case (-2^(W-1) / -1): lo = 0x80..0, hi = 0. No flag.
- Latency: accept edge E0 -> hi/lo valid and done=1 after edge E(WIDTH+1).
  - busy=1 from after E0 through the FIX edge, i.e. for WIDTH+1 cycles.
  - busy=0 in the same cycle that done=1.
  - For divide-by-zero: 1 busy cycle.
- start while busy: ignored, with no side effects. The controller must hold the request and retry.
- start in the done cycle: accepted; back-to-back operation is allowed.
- hi/lo are stable throughout a mul/div. They change only at the FIX edge, at reset, or on MTHI/MTLO.
- Operand inputs are sampled only at E0; they may change freely afterwards.

Decomposition:
- Package mips_cpu_pkg:
  - funct localparams FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO.
  - typedef enum muldiv_state_t {IDLE, MUL, DIV, FIX}.
- One natural sub-module, mips_cpu_div_step: combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Lets the divider datapath be unit-tested in isolation.
- Multiply add-shift, sign handling and the FSM stay in the top module.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 33 edges after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7 -> lo=14, hi=2; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x1234 and lo=0x5678 via MTHI/MTLO, then DIV 5 / 0 -> done and div_zero pulse after 1 edge; hi=0x1234, lo=0x5678 unchanged.
- MULTU 2x3 accepted, then start with DIVU and then MTHI mid-operation -> both ignored; final hi=0, lo=6. Next start issued in the done cycle is accepted.
- MULT in progress, reset_n pulsed low at iteration 10 -> hi=lo=0, busy=0 immediately; no done pulse afterwards. A new MULTU 5x5 completes with lo=25.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared constants and types for the MIPS mul/div unit.
//   FUNCT_*         : R-type funct codes handled by the HI/LO unit
//   muldiv_state_t  : controller state encoding
package mips_cpu_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if: request/response bundle between the execute-stage
// controller (master) and the mul/div unit (slave).
//   start/funct/rs_content/rt_content : request, sampled on accept edge
//   busy/done/div_zero                : status
//   hi/lo                             : architectural HI/LO registers
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_content;
  logic [WIDTH-1:0] rt_content;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, rs_content, rt_content,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, funct, rs_content, rt_content,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mips_cpu_div_step.sv
// mips_cpu_div_step: one combinational restoring-division step.
//   rem_in       : partial remainder (always < divisor)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
module mips_cpu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};

  // rem_in < divisor bounds shifted below 2*divisor, so the top bit of the
  // difference is set exactly when the trial subtraction borrows.
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative radix-2 multiply/divide unit owning HI/LO.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : start/funct/rs_content/rt_content request in,
//                  busy/done/div_zero status and hi/lo out
// One add-shift or restoring step per cycle on a shared 2*WIDTH register:
// upper half = running product high / partial remainder, lower half =
// multiplier being consumed / dividend shifting out and quotient shifting in.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  mips_cpu_muldiv_if.slave bus
);

  muldiv_state_t      state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic               neg_q;     // negate product / quotient in FIX
  logic               neg_r;     // negate remainder in FIX
  logic               dz;        // divide-by-zero in flight
  logic               op_mul;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  // request decode
  logic             accept, is_mul, is_div, is_signed, rs_neg, rt_neg, rt_zero;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign accept    = bus.start && (state == IDLE);
  assign is_mul    = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
  assign is_div    = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
  assign is_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
  assign rs_neg    = is_signed && bus.rs_content[WIDTH-1];
  assign rt_neg    = is_signed && bus.rt_content[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_content : bus.rs_content;
  assign rt_mag    = rt_neg ? -bus.rt_content : bus.rt_content;
  assign rt_zero   = (bus.rt_content == '0);

  // multiply add-shift step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // restoring division step
  logic [WIDTH-1:0]   rem_nxt;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_nxt;

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc[WIDTH-1]),
    .divisor      (opnd),
    .rem_out      (rem_nxt),
    .q_bit        (q_bit)
  );
  assign div_nxt = {rem_nxt, acc[WIDTH-2:0], q_bit};

  // sign fix-up
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = rt_zero ? FIX : DIV;
      end
      MUL, DIV: if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // datapath and HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      op_mul <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      dz_q   <= (state == FIX) && dz;
      case (state)
        IDLE: if (accept) begin
          case (bus.funct)
            FUNCT_MTHI: hi_q <= bus.rs_content;
            FUNCT_MTLO: lo_q <= bus.rs_content;
            FUNCT_MULT, FUNCT_MULTU: begin
              acc    <= {{WIDTH{1'b0}}, rt_mag};
              opnd   <= rs_mag;
              neg_q  <= rs_neg ^ rt_neg;
              neg_r  <= 1'b0;
              dz     <= 1'b0;
              op_mul <= 1'b1;
              cnt    <= CNT_W'(WIDTH);
            end
            FUNCT_DIV, FUNCT_DIVU: begin
              acc    <= {{WIDTH{1'b0}}, rs_mag};
              opnd   <= rt_mag;
              neg_q  <= rs_neg ^ rt_neg;
              neg_r  <= rs_neg;
              dz     <= rt_zero;
              op_mul <= 1'b0;
              cnt    <= CNT_W'(WIDTH);
            end
            default: ;
          endcase
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt - CNT_W'(1);
        end
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (op_mul)   {hi_q, lo_q} <= prod_fix;
          else if (!dz) {hi_q, lo_q} <= {rem_fix, quot_fix};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed-vector bench for mips_cpu_muldiv.
module tb_mips_cpu_muldiv;
  import mips_cpu_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // present a request for one cycle; returns 1ns after the accept edge with
  // operands scrambled so late sampling would be caught
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.funct = f; bus.rs_content = a; bus.rt_content = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.funct = 6'h00;
    bus.rs_content = $urandom; bus.rt_content = $urandom;
  endtask

  // edges until done is seen (bounded) and busy samples along the way
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.funct = 6'h00; bus.rs_content = '0; bus.rt_content = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", bus.div_zero); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_multu_max();
    int e, b;
    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", e); end
    checks++; if (b !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", b); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want %h", bus.hi, 32'hFFFF_FFFE); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want %h", bus.lo, 32'h1); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL multu_dz: got %b want 0", bus.div_zero); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_signed();
    int e, b;
    issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(e, b);
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want %h", bus.hi, 32'hFFFF_FFFF); end
    checks++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo: got %h want %h", bus.lo, 32'hFFFF_FFEB); end
    issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", e); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want %h", bus.lo, 32'hFFFF_FFFD); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want %h", bus.hi, 32'hFFFF_FFFF); end
    issue(FUNCT_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(e, b);
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdiv_lo: got %h want %h", bus.lo, 32'hFFFF_FFFD); end
    checks++; if (bus.hi !== 32'h0000_0001) begin errors++; $display("FAIL div_negdiv_hi: got %h want %h", bus.hi, 32'h1); end
  endtask

  task automatic test_divu();
    int e, b;
    issue(FUNCT_DIVU, 32'd100, 32'd7);
    wait_done(e, b);
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want %h", bus.lo, 32'd14); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want %h", bus.hi, 32'd2); end
    issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e, b);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want %h", bus.lo, 32'h8000_0000); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dz: got %b want 0", bus.div_zero); end
  endtask

  task automatic test_div_zero();
    int e, b;
    issue(FUNCT_MTHI, 32'h0000_1234, 32'h0);
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi: got %h want %h", bus.hi, 32'h1234); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    issue(FUNCT_MTLO, 32'h0000_5678, 32'h0);
    checks++; if (bus.lo !== 32'h0000_5678) begin errors++; $display("FAIL mtlo_lo: got %h want %h", bus.lo, 32'h5678); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b want 0", bus.done); end
    issue(FUNCT_DIV, 32'd5, 32'd0);
    wait_done(e, b);
    checks++; if (e !== 1) begin errors++; $display("FAIL divz_latency: got %0d want 1", e); end
    checks++; if (b !== 1) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 1", b); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL divz_flag: got %b want 1", bus.div_zero); end
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL divz_hi: got %h want %h", bus.hi, 32'h1234); end
    checks++; if (bus.lo !== 32'h0000_5678) begin errors++; $display("FAIL divz_lo: got %h want %h", bus.lo, 32'h5678); end
    @(posedge clk); #1;
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL divz_pulse: got %b want 0", bus.div_zero); end
  endtask

  task automatic test_back_to_back();
    int e, b;
    issue(FUNCT_MULTU, 32'd2, 32'd3);
    repeat (3) @(posedge clk);
    issue(FUNCT_DIVU, 32'd100, 32'd7);
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL busy_hi_stable: got %h want %h", bus.hi, 32'h1234); end
    issue(FUNCT_MTHI, 32'hDEAD_BEEF, 32'h0);
    checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL busy_mthi_ignored: got %h want %h", bus.hi, 32'h1234); end
    wait_done(e, b);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL b2b_hi: got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'd6) begin errors++; $display("FAIL b2b_lo: got %h want %h", bus.lo, 32'd6); end
    // issued inside the done cycle
    issue(FUNCT_MULTU, 32'd4, 32'd5);
    wait_done(e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", e); end
    checks++; if (bus.lo !== 32'd20) begin errors++; $display("FAIL b2b_second_lo: got %h want %h", bus.lo, 32'd20); end
  endtask

  task automatic test_reset_mid();
    int e, b;
    bit seen_done;
    issue(FUNCT_MULT, 32'h1234_5678, 32'hFFFF_FFFD);
    repeat (10) @(posedge clk);
    #1; reset_n = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    @(negedge clk); reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b want 0", seen_done); end
    issue(FUNCT_MULTU, 32'd5, 32'd5);
    wait_done(e, b);
    checks++; if (e !== 33) begin errors++; $display("FAIL rst_after_latency: got %0d want 33", e); end
    checks++; if (bus.lo !== 32'd25) begin errors++; $display("FAIL rst_after_lo: got %h want %h", bus.lo, 32'd25); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rst_after_hi: got %h want %h", bus.hi, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_divu();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
